keypad_entry_ctrl: RTL and testbench
====================================

Name: keypad_entry_ctrl

Overview:
Sequences microwave keypad entry. It samples the 10-line one-hot keypad, qualifies each press as a single event with optional debounce and wait-for-release, and converts it to BCD. Accepted digits shift into a 4-digit MM:SS entry register. On start, a req/ack handshake hands the entered time to the countdown timer. It sits between the raw keypad and the timer/display datapath.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable samples required before a key is accepted (1..15); used only when KEYPAD_DEBOUNCE_EN is defined.

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
keyboard  in  10  one-hot keypad; bit i high = digit i pressed
enablen  in  1  active-low entry enable; high (timer running / door open) = keys ignored
clearn  in  1  synchronous active-low clear of entry
start  in  1  single-cycle request to load entered time
load_ack  in  1  timer accepted the loaded time
key_strobe  out  1  1-cycle pulse when a digit is accepted
key_bcd  out  4  BCD of the last accepted digit
sec_ones, sec_tens, min_ones, min_tens  out  4 each  entry digits
digit_count  out  3  digits entered, 0..4
load_req  out  1  entered time is valid for the timer
time_err  out  1  1-cycle pulse: start rejected because sec_tens > 5

Behaviour:
- Reset (resetn=0, async): all outputs 0; key FSM in IDLE; debounce counter 0.
- keyboard is registered once (kb_q) before use. Key valid = kb_q exactly one-hot. All-zero or multi-hot = no key.
- Key FSM:
  - IDLE -> DEBOUNCE on a valid key while enablen=0, load_req=0, and digit_count<4; captures the key value and sets cnt=1.
  - DEBOUNCE -> IDLE if kb_q differs from the captured value.
  - DEBOUNCE -> HELD when cnt reaches DEBOUNCE_CYCLES. This performs the capture.
  - HELD -> IDLE when kb_q = 0.
- Capture:
  - key_bcd = index of the set bit; key_strobe = 1 for one cycle.
  - Digits shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=new.
  - digit_count increments and saturates at 4. At 4, further keys are ignored; no strobe is issued.
- Latency: key_strobe is high after edge N+1 from the first edge that samples a stable key. N = DEBOUNCE_CYCLES with the feature defined, 1 without.
- Holding a key yields exactly one capture; a re-press requires release.
- Load handshake:
  - start while load_req=0, digit_count>0, sec_tens<=5 -> load_req=1 next cycle.
  - Digits and count are frozen and keys are ignored while load_req=1.
  - load_ack sampled high with load_req=1 -> next cycle: load_req=0, digits=0, count=0.
  - start with count=0 -> ignored.
  - start with sec_tens>5 -> time_err pulse, no load, entry kept.
  - start while load_req=1 -> ignored.
  - load_ack without load_req -> ignored.
- clearn=0: next edge zeroes digits, count, load_req, key_bcd; FSM -> HELD if a key is present, else IDLE. This aborts an outstanding load.
- Priority: clearn > load_ack > capture > start. start in the same cycle as a capture is dropped.
- enablen rising mid-DEBOUNCE: FSM -> IDLE with no capture. A FSM in HELD stays in HELD until release.

Optional Feature:
- KEYPAD_DEBOUNCE_EN defined: DEBOUNCE state and counter (4 bits) are present; capture needs DEBOUNCE_CYCLES stable samples.
- Undefined: DEBOUNCE state and counter are removed. IDLE captures directly on a valid key and goes to HELD (1-sample acceptance); DEBOUNCE_CYCLES is unused.

Decomposition:
- Package keypad_pkg holds:
  - key FSM state encoding (IDLE, DEBOUNCE, HELD);
  - MAX_DIGITS=4 and SEC_TENS_MAX=5;
  - BCD width 4;
  - one-hot-to-BCD conversion function with one-hot check.
- One sub-module, key_qualifier: input register, one-hot check, FSM, debounce counter. Outputs a capture pulse and BCD.
- The top level holds the shift register, count, and load handshake.

Test Plan:
- Feature on, DEBOUNCE_CYCLES=4: press bit 5 held 10 cycles then release -> one key_strobe after edge 5, key_bcd=5, sec_ones=5, digit_count=1.
- Keys 1,2,3,0 (each press/release) -> min_tens=1, min_ones=2, sec_tens=3, sec_ones=0, count=4; fifth key 7 -> no strobe, digits unchanged.
- Entry 1,3,0 then start -> load_req=1 next cycle; key 9 ignored; load_ack after 3 cycles -> load_req=0, all digits 0, count=0.
- Entry 7,5 (sec_tens=7) then start -> time_err pulse, load_req stays 0, digits kept; clearn=0 -> all 0.
- Bounce: bit 4 for 2 cycles, then 0, then bit 4 for 5 cycles -> exactly one capture of 4. Keyboard 10'b0000000110 held -> no capture.
- Assert resetn=0 mid-DEBOUNCE and during load_req=1 -> all outputs 0 immediately (async); no strobe after release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for keypad entry: key FSM encoding, entry limits and
// one-hot keypad decoding.
package keypad_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StHeld
  } key_state_e;

  localparam int unsigned MAX_DIGITS   = 4;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned BCD_W        = 4;
  localparam int unsigned NUM_KEYS     = 10;

  typedef struct packed {
    logic             valid;
    logic [BCD_W-1:0] bcd;
  } key_dec_t;

  // valid only when exactly one line is set; bcd is the index of the set line.
  function automatic key_dec_t onehot_to_bcd(input logic [NUM_KEYS-1:0] oh);
    key_dec_t    r;
    int unsigned n;
    r = '0;
    n = 0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (oh[i]) begin
        n++;
        r.bcd = BCD_W'(i);
      end
    end
    r.valid = (n == 1);
    return r;
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Keypad-side and timer-side signals of keypad_entry_ctrl. slave is the
// controller's view, master the view of whatever drives the keypad and timer.
interface keypad_entry_ctrl_if;
  import keypad_pkg::*;

  logic [NUM_KEYS-1:0] keyboard;
  logic                enablen;
  logic                clearn;
  logic                start;
  logic                load_ack;
  logic                key_strobe;
  logic [BCD_W-1:0]    key_bcd;
  logic [BCD_W-1:0]    sec_ones;
  logic [BCD_W-1:0]    sec_tens;
  logic [BCD_W-1:0]    min_ones;
  logic [BCD_W-1:0]    min_tens;
  logic [2:0]          digit_count;
  logic                load_req;
  logic                time_err;

  modport slave (
    input  keyboard, enablen, clearn, start, load_ack,
    output key_strobe, key_bcd, sec_ones, sec_tens, min_ones, min_tens,
           digit_count, load_req, time_err
  );

  modport master (
    output keyboard, enablen, clearn, start, load_ack,
    input  key_strobe, key_bcd, sec_ones, sec_tens, min_ones, min_tens,
           digit_count, load_req, time_err
  );
endinterface

// File: rtl/key_qualifier.sv
// Registers the keypad, qualifies each press as a single capture event.
// KEYPAD_DEBOUNCE_EN adds the DEBOUNCE state and its stable-sample counter.
module key_qualifier
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                clearn,
  input  logic [NUM_KEYS-1:0] keyboard,
  input  logic                accept_en,
  output logic                cap,
  output logic [BCD_W-1:0]    cap_bcd
);

  logic [NUM_KEYS-1:0] kb_q;
  key_state_e          state_q;
  key_dec_t            dec;

`ifdef KEYPAD_DEBOUNCE_EN
  localparam logic [3:0] DebLast = 4'(DEBOUNCE_CYCLES - 1);
  logic [NUM_KEYS-1:0] key_q;
  logic [3:0]          cnt_q;
`endif

  assign dec     = onehot_to_bcd(kb_q);
  assign cap_bcd = dec.bcd;

  always_comb begin
    cap = 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
    // A single required sample needs no DEBOUNCE pass.
    if (state_q == StIdle) begin
      cap = accept_en && dec.valid && (DEBOUNCE_CYCLES <= 1);
    end else if (state_q == StDebounce) begin
      cap = accept_en && (kb_q == key_q) && (cnt_q >= DebLast);
    end
`else
    cap = (state_q == StIdle) && accept_en && dec.valid;
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      kb_q    <= '0;
      state_q <= StIdle;
`ifdef KEYPAD_DEBOUNCE_EN
      key_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      kb_q <= keyboard;
      if (!clearn) begin
        // A key still down across a clear must be released before it counts.
        state_q <= (kb_q != '0) ? StHeld : StIdle;
`ifdef KEYPAD_DEBOUNCE_EN
        cnt_q   <= '0;
`endif
      end else begin
        case (state_q)
          StIdle: begin
            if (cap) begin
              state_q <= StHeld;
`ifdef KEYPAD_DEBOUNCE_EN
            end else if (accept_en && dec.valid) begin
              state_q <= StDebounce;
              key_q   <= kb_q;
              cnt_q   <= 4'd1;
`endif
            end
          end
`ifdef KEYPAD_DEBOUNCE_EN
          StDebounce: begin
            if (cap) begin
              state_q <= StHeld;
              cnt_q   <= '0;
            end else if (!accept_en || (kb_q != key_q)) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
`endif
          StHeld: begin
            if (kb_q == '0) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Microwave keypad entry: MM:SS shift register, digit count and timer load
// handshake. Optional debounce via KEYPAD_DEBOUNCE_EN (see key_qualifier).
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic                 clock,
  input logic                 resetn,
  keypad_entry_ctrl_if.slave  kp
);

  // dig_q[0] = sec_ones ... dig_q[3] = min_tens
  logic [3:0][BCD_W-1:0] dig_q;
  logic [2:0]            count_q;
  logic                  load_req_q;
  logic                  key_strobe_q;
  logic                  time_err_q;
  logic [BCD_W-1:0]      key_bcd_q;
  logic                  accept_en;
  logic                  cap;
  logic [BCD_W-1:0]      cap_bcd;

  assign accept_en = ~kp.enablen & ~load_req_q & (count_q < 3'(MAX_DIGITS));

  key_qualifier #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_qualifier (
    .clock    (clock),
    .resetn   (resetn),
    .clearn   (kp.clearn),
    .keyboard (kp.keyboard),
    .accept_en(accept_en),
    .cap      (cap),
    .cap_bcd  (cap_bcd)
  );

  // Priority: clear, then load_ack, then capture, then start.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dig_q        <= '0;
      count_q      <= '0;
      load_req_q   <= 1'b0;
      key_strobe_q <= 1'b0;
      time_err_q   <= 1'b0;
      key_bcd_q    <= '0;
    end else begin
      key_strobe_q <= 1'b0;
      time_err_q   <= 1'b0;
      if (!kp.clearn) begin
        dig_q      <= '0;
        count_q    <= '0;
        load_req_q <= 1'b0;
        key_bcd_q  <= '0;
      end else if (load_req_q && kp.load_ack) begin
        dig_q      <= '0;
        count_q    <= '0;
        load_req_q <= 1'b0;
      end else if (cap) begin
        dig_q        <= {dig_q[2:0], cap_bcd};
        key_bcd_q    <= cap_bcd;
        key_strobe_q <= 1'b1;
        if (count_q < 3'(MAX_DIGITS)) count_q <= count_q + 3'd1;
      end else if (kp.start && !load_req_q && (count_q != '0)) begin
        if (dig_q[1] > BCD_W'(SEC_TENS_MAX)) time_err_q <= 1'b1;
        else                                 load_req_q <= 1'b1;
      end
    end
  end

  assign kp.key_strobe  = key_strobe_q;
  assign kp.key_bcd     = key_bcd_q;
  assign kp.sec_ones    = dig_q[0];
  assign kp.sec_tens    = dig_q[1];
  assign kp.min_ones    = dig_q[2];
  assign kp.min_tens    = dig_q[3];
  assign kp.digit_count = count_q;
  assign kp.load_req    = load_req_q;
  assign kp.time_err    = time_err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl: vector table plus hand-written
// sequences for bounce, enable abort and asynchronous reset.
module tb_keypad_entry_ctrl;

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int Lat = 4;
`else
  localparam int Lat = 1;
`endif
  localparam int P = Lat + 1;

  logic clock = 1'b0;
  logic resetn = 1'b0;

  keypad_entry_ctrl_if kp();

  keypad_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clock (clock),
    .resetn(resetn),
    .kp    (kp)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0]  kb;
    logic        en_n, clr_n, st, ack;
    int          cyc;
    logic        e_stb;
    logic [3:0]  e_bcd;
    logic [15:0] e_dig;
    logic [2:0]  e_cnt;
    logic        e_req, e_err;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_stb = 0;

  function automatic logic [9:0] k(input int i);
    logic [9:0] one;
    one = 10'd1;
    return one << i;
  endfunction

  function automatic void add(input logic [9:0] kb, input logic en_n, input logic clr_n,
                              input logic st, input logic ack, input int cyc,
                              input logic stb, input logic [3:0] bcd, input logic [15:0] dig,
                              input logic [2:0] cnt, input logic req, input logic err);
    vec_t v;
    v.kb = kb; v.en_n = en_n; v.clr_n = clr_n; v.st = st; v.ack = ack; v.cyc = cyc;
    v.e_stb = stb; v.e_bcd = bcd; v.e_dig = dig; v.e_cnt = cnt; v.e_req = req; v.e_err = err;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic [9:0] kb, input logic en_n, input logic clr_n,
                       input logic st, input logic ack);
    kp.keyboard = kb; kp.enablen = en_n; kp.clearn = clr_n; kp.start = st; kp.load_ack = ack;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (kp.key_strobe) n_stb++;
  endtask

  task automatic check(input string nm, input logic stb, input logic [3:0] bcd,
                       input logic [15:0] dig, input logic [2:0] cnt, input logic req,
                       input logic err);
    logic [15:0] a_dig;
    a_dig = {kp.min_tens, kp.min_ones, kp.sec_tens, kp.sec_ones};
    n_vec++;
    if (kp.key_strobe !== stb || kp.key_bcd !== bcd || a_dig !== dig ||
        kp.digit_count !== cnt || kp.load_req !== req || kp.time_err !== err) begin
      n_bad++;
      $display("FAIL %s: got stb=%b bcd=%0d dig=%h cnt=%0d req=%b err=%b, want stb=%b bcd=%0d dig=%h cnt=%0d req=%b err=%b",
               nm, kp.key_strobe, kp.key_bcd, a_dig, kp.digit_count, kp.load_req, kp.time_err,
               stb, bcd, dig, cnt, req, err);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  initial begin
    int s0;
    drive(10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #12;
    check("reset", 0, 0, 16'h0000, 0, 0, 0);
    resetn = 1'b1;
    tick();

    // kb, en_n, clr_n, st, ack, cycles -> stb, bcd, digits, count, req, err
    add(k(5), 0, 1, 0, 0, P,   1, 5, 16'h0005, 1, 0, 0);
    add(k(5), 0, 1, 0, 0, 8,   0, 5, 16'h0005, 1, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 5, 16'h0005, 1, 0, 0);
    add(0,    0, 0, 0, 0, 1,   0, 0, 16'h0000, 0, 0, 0);
    add(k(1), 0, 1, 0, 0, P,   1, 1, 16'h0001, 1, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 1, 16'h0001, 1, 0, 0);
    add(k(2), 0, 1, 0, 0, P,   1, 2, 16'h0012, 2, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 2, 16'h0012, 2, 0, 0);
    add(k(3), 0, 1, 0, 0, P,   1, 3, 16'h0123, 3, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 3, 16'h0123, 3, 0, 0);
    add(k(0), 0, 1, 0, 0, P,   1, 0, 16'h1230, 4, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 0, 16'h1230, 4, 0, 0);
    add(k(7), 0, 1, 0, 0, P,   0, 0, 16'h1230, 4, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 0, 16'h1230, 4, 0, 0);
    add(0,    0, 0, 0, 0, 1,   0, 0, 16'h0000, 0, 0, 0);
    add(k(1), 0, 1, 0, 0, P,   1, 1, 16'h0001, 1, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 1, 16'h0001, 1, 0, 0);
    add(k(3), 0, 1, 0, 0, P,   1, 3, 16'h0013, 2, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 3, 16'h0013, 2, 0, 0);
    add(k(0), 0, 1, 0, 0, P,   1, 0, 16'h0130, 3, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 0, 16'h0130, 3, 0, 0);
    add(0,    0, 1, 1, 0, 1,   0, 0, 16'h0130, 3, 1, 0);
    add(k(9), 0, 1, 0, 0, P+2, 0, 0, 16'h0130, 3, 1, 0);
    add(0,    0, 1, 0, 0, 3,   0, 0, 16'h0130, 3, 1, 0);
    add(0,    0, 1, 0, 1, 1,   0, 0, 16'h0000, 0, 0, 0);
    add(0,    0, 1, 0, 1, 1,   0, 0, 16'h0000, 0, 0, 0);
    add(0,    0, 1, 1, 0, 1,   0, 0, 16'h0000, 0, 0, 0);
    add(k(7), 0, 1, 0, 0, P,   1, 7, 16'h0007, 1, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 7, 16'h0007, 1, 0, 0);
    add(k(5), 0, 1, 0, 0, P,   1, 5, 16'h0075, 2, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 5, 16'h0075, 2, 0, 0);
    add(0,    0, 1, 1, 0, 1,   0, 5, 16'h0075, 2, 0, 1);
    add(0,    0, 1, 0, 0, 1,   0, 5, 16'h0075, 2, 0, 0);
    add(0,    0, 0, 0, 0, 1,   0, 0, 16'h0000, 0, 0, 0);
    add(k(6), 1, 1, 0, 0, P+2, 0, 0, 16'h0000, 0, 0, 0);
    add(0,    1, 1, 0, 0, 2,   0, 0, 16'h0000, 0, 0, 0);
    add(10'b0000000110, 0, 1, 0, 0, P+3, 0, 0, 16'h0000, 0, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 0, 16'h0000, 0, 0, 0);
    add(k(2), 0, 1, 0, 0, P,   1, 2, 16'h0002, 1, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 2, 16'h0002, 1, 0, 0);
    add(0,    0, 1, 1, 0, 1,   0, 2, 16'h0002, 1, 1, 0);
    add(k(4), 0, 1, 0, 0, 1,   0, 2, 16'h0002, 1, 1, 0);
    add(k(4), 0, 0, 0, 0, 1,   0, 0, 16'h0000, 0, 0, 0);
    add(k(4), 0, 1, 0, 0, P+2, 0, 0, 16'h0000, 0, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 0, 16'h0000, 0, 0, 0);
    add(k(4), 0, 1, 0, 0, P,   1, 4, 16'h0004, 1, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 4, 16'h0004, 1, 0, 0);
    add(k(8), 0, 1, 0, 0, Lat, 0, 4, 16'h0004, 1, 0, 0);
    add(k(8), 0, 1, 1, 0, 1,   1, 8, 16'h0048, 2, 0, 0);
    add(0,    0, 1, 0, 0, 2,   0, 8, 16'h0048, 2, 0, 0);
    add(0,    0, 0, 0, 0, 1,   0, 0, 16'h0000, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].kb, tbl[i].en_n, tbl[i].clr_n, tbl[i].st, tbl[i].ack);
      repeat (tbl[i].cyc) tick();
      check($sformatf("vec%0d", i), tbl[i].e_stb, tbl[i].e_bcd, tbl[i].e_dig, tbl[i].e_cnt,
            tbl[i].e_req, tbl[i].e_err);
    end
    drive(10'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Bounce: 2 samples, a gap, then 5 samples of the same key.
    s0 = n_stb;
    kp.keyboard = k(4); repeat (2) tick();
    kp.keyboard = '0;   tick();
    kp.keyboard = k(4); repeat (5) tick();
    kp.keyboard = '0;   repeat (3) tick();
    check_int("bounce_strobes", n_stb - s0, (Lat > 1) ? 1 : 2);
    check("bounce_state", 0, 4, (Lat > 1) ? 16'h0004 : 16'h0044, (Lat > 1) ? 1 : 2, 0, 0);
    kp.clearn = 1'b0; tick(); kp.clearn = 1'b1;

    // enablen rising while a key is being qualified.
    kp.keyboard = k(6);
    repeat ((Lat > 1) ? 2 : 1) tick();
    kp.enablen = 1'b1;
    s0 = n_stb;
    repeat (P + 2) tick();
    check_int("enable_abort_strobes", n_stb - s0, 0);
    kp.keyboard = '0; repeat (2) tick(); kp.enablen = 1'b0;
    check("enable_abort_state", 0, 0, 16'h0000, 0, 0, 0);

    // Asynchronous reset in the middle of a press.
    kp.keyboard = k(3); repeat (P) tick();
    kp.keyboard = '0;   repeat (2) tick();
    kp.keyboard = k(8); repeat (2) tick();
    #3 resetn = 1'b0;
    #1 check("async_rst_debounce", 0, 0, 16'h0000, 0, 0, 0);
    kp.keyboard = '0;
    #2 resetn = 1'b1;
    s0 = n_stb;
    repeat (4) tick();
    check_int("post_rst_strobes", n_stb - s0, 0);

    // Asynchronous reset with a load outstanding.
    kp.keyboard = k(2); repeat (P) tick();
    kp.keyboard = '0;   repeat (2) tick();
    kp.start = 1'b1; tick(); kp.start = 1'b0;
    check("pre_rst_req", 0, 2, 16'h0002, 1, 1, 0);
    #2 resetn = 1'b0;
    #1 check("async_rst_req", 0, 0, 16'h0000, 0, 0, 0);
    #2 resetn = 1'b1;
    tick();
    check("post_rst_req", 0, 0, 16'h0000, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
